// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver with 2-flop input synchronizer, mid-bit sampling and a
// small valid/ready output FIFO that reports framing errors and dropped bytes.
module uart_rx_monitor #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  input  logic       byte_ready_i,
  output logic       frame_err_o,
  output logic       overflow_o,
  output logic [7:0] drop_cnt_o,
  output logic       busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rxs_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          frame_err_q, frame_err_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic push, pop, wr_en, drop, fifo_empty, fifo_full;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rxs_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxs_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BREAK: begin
        // Stay here until the line returns high so a held break reports once.
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign pop        = !fifo_empty && byte_ready_i;
  assign wr_en      = push && (!fifo_full || pop);
  assign drop       = push && fifo_full && !pop;

  always_comb begin
    wr_ptr_d   = wr_en ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d   = pop   ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    overflow_d = overflow_q | drop;
    drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      rx_meta_q   <= rx;
      rxs_q       <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
  end

  assign byte_o       = fifo_empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign byte_valid_o = !fifo_empty;
  assign frame_err_o  = frame_err_q;
  assign overflow_o   = overflow_q;
  assign drop_cnt_o   = drop_cnt_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Self-checking bench for uart_rx_monitor: scenario tasks drive serial frames
// and compare delivered bytes/flags against a queue-based reference model.
module tb_uart_rx_monitor;

  localparam int C     = 16;
  localparam int H     = C / 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] byte_o;
  logic       byte_valid_o;
  logic       byte_ready_i = 1'b0;
  logic       frame_err_o;
  logic       overflow_o;
  logic [7:0] drop_cnt_o;
  logic       busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx_monitor #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .byte_o       (byte_o),
    .byte_valid_o (byte_valid_o),
    .byte_ready_i (byte_ready_i),
    .frame_err_o  (frame_err_o),
    .overflow_o   (overflow_o),
    .drop_cnt_o   (drop_cnt_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  // Observation side: everything sampled on the falling edge.
  logic [7:0] got[$];
  int cyc = 0, valid_hi = 0, err_hi = 0, busy_rise = 0, valid_rise = 0;
  logic busy_prev = 1'b0, valid_prev = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (byte_valid_o && byte_ready_i) got.push_back(byte_o);
    if (byte_valid_o) valid_hi = valid_hi + 1;
    if (frame_err_o) err_hi = err_hi + 1;
    if (busy_o && !busy_prev) busy_rise = cyc;
    if (byte_valid_o && !valid_prev) valid_rise = cyc;
    busy_prev  = busy_o;
    valid_prev = byte_valid_o;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves rx at the stop-bit level so a bad stop can be extended into a break.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    $display("[TB] frame 0x%02h stop=%0b", b, stop);
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(C);
    end
    rx = stop;
    tick(C);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx = 1'b1; byte_ready_i = 1'b0;
    tick(3);
    n_tests++; if (byte_o !== 8'h00)     begin n_fail++; $display("FAIL reset_byte got=%h exp=00", byte_o); end
    n_tests++; if (byte_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", byte_valid_o); end
    n_tests++; if (frame_err_o !== 1'b0)  begin n_fail++; $display("FAIL reset_ferr got=%b exp=0", frame_err_o); end
    n_tests++; if (overflow_o !== 1'b0)   begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", overflow_o); end
    n_tests++; if (drop_cnt_o !== 8'h00)  begin n_fail++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt_o); end
    n_tests++; if (busy_o !== 1'b0)       begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    rst_n = 1'b1;
    tick(5);
    n_tests++; if (busy_o !== 1'b0 || byte_valid_o !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset busy=%b valid=%b exp=0/0", busy_o, byte_valid_o); end
  endtask

  task automatic test_single_frame();
    int gb, vb, eb;
    byte_ready_i = 1'b1;
    gb = got.size(); vb = valid_hi; eb = err_hi;
    send_frame(8'h5A, 1'b1);
    tick(20);
    n_tests++; if (got.size() - gb != 1) begin n_fail++; $display("FAIL single_count got=%0d exp=1", got.size() - gb); end
    else begin
      n_tests++; if (got[gb] !== 8'h5A) begin n_fail++; $display("FAIL single_data got=%h exp=5a", got[gb]); end
    end
    n_tests++; if (valid_hi - vb != 1) begin n_fail++; $display("FAIL single_valid_width got=%0d exp=1", valid_hi - vb); end
    n_tests++; if (err_hi != eb) begin n_fail++; $display("FAIL single_ferr got=%0d exp=0", err_hi - eb); end
    n_tests++; if (valid_rise - busy_rise != H + 9 * C) begin n_fail++; $display("FAIL single_latency got=%0d exp=%0d", valid_rise - busy_rise, H + 9 * C); end
  endtask

  task automatic test_back_to_back();
    byte_ready_i = 1'b0;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(20);
    n_tests++; if (byte_valid_o !== 1'b1 || byte_o !== 8'h00) begin n_fail++; $display("FAIL b2b_head0 valid=%b byte=%h exp=1/00", byte_valid_o, byte_o); end
    byte_ready_i = 1'b1; tick(1); byte_ready_i = 1'b0;
    n_tests++; if (byte_valid_o !== 1'b1 || byte_o !== 8'hFF) begin n_fail++; $display("FAIL b2b_head1 valid=%b byte=%h exp=1/ff", byte_valid_o, byte_o); end
    tick(3);
    n_tests++; if (byte_o !== 8'hFF) begin n_fail++; $display("FAIL b2b_hold byte=%h exp=ff", byte_o); end
    byte_ready_i = 1'b1; tick(1); byte_ready_i = 1'b0;
    n_tests++; if (byte_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_empty valid=%b exp=0", byte_valid_o); end
  endtask

  task automatic test_glitch();
    int gb, eb, waited;
    byte_ready_i = 1'b1;
    gb = got.size(); eb = err_hi;
    rx = 1'b0; tick(3);
    n_tests++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_rise got=%b exp=1", busy_o); end
    rx = 1'b1;
    waited = 0;
    while (busy_o === 1'b1 && waited < H + 3) begin tick(1); waited++; end
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_drop got=%b exp=0 within %0d cycles", busy_o, H + 3); end
    tick(2 * C);
    n_tests++; if (got.size() != gb || err_hi != eb) begin n_fail++; $display("FAIL glitch_quiet bytes=%0d errs=%0d exp=0/0", got.size() - gb, err_hi - eb); end
  endtask

  task automatic test_frame_error();
    int gb, eb;
    byte_ready_i = 1'b1;
    gb = got.size(); eb = err_hi;
    send_frame(8'h41, 1'b0);
    tick(40);
    rx = 1'b1; tick(C);
    send_frame(8'h42, 1'b1);
    tick(20);
    n_tests++; if (err_hi - eb != 1) begin n_fail++; $display("FAIL ferr_pulses got=%0d exp=1", err_hi - eb); end
    n_tests++; if (got.size() - gb != 1) begin n_fail++; $display("FAIL ferr_count got=%0d exp=1", got.size() - gb); end
    else begin
      n_tests++; if (got[gb] !== 8'h42) begin n_fail++; $display("FAIL ferr_data got=%h exp=42", got[gb]); end
    end
    n_tests++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL ferr_ovf got=%b exp=0", overflow_o); end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int gb, eb, exp_err;
    logic [7:0] b;
    logic stop;
    byte_ready_i = 1'b1;
    gb = got.size(); eb = err_hi; exp_err = 0;
    for (int k = 0; k < 10; k++) begin
      b = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop);
      if (stop) exp_q.push_back(b);
      else exp_err++;
      rx = 1'b1;
      tick(stop ? $urandom_range(0, 12) : $urandom_range(4, 12));
    end
    tick(20);
    n_tests++; if (err_hi - eb != exp_err) begin n_fail++; $display("FAIL rand_errs got=%0d exp=%0d", err_hi - eb, exp_err); end
    n_tests++; if (got.size() - gb != exp_q.size()) begin n_fail++; $display("FAIL rand_count got=%0d exp=%0d", got.size() - gb, exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_tests++; if (got[gb + i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, got[gb + i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_q[$];
    int gb, drops;
    byte_ready_i = 1'b0;
    drops = 0;
    for (int k = 1; k <= 6; k++) begin
      send_frame(8'(k), 1'b1);
      if (exp_q.size() < DEPTH) exp_q.push_back(8'(k));
      else drops++;
    end
    tick(20);
    n_tests++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", overflow_o); end
    n_tests++; if (drop_cnt_o !== 8'(drops)) begin n_fail++; $display("FAIL ovf_drops got=%0d exp=%0d", drop_cnt_o, drops); end
    gb = got.size();
    byte_ready_i = 1'b1; tick(10); byte_ready_i = 1'b0;
    n_tests++; if (got.size() - gb != exp_q.size()) begin n_fail++; $display("FAIL ovf_drain_count got=%0d exp=%0d", got.size() - gb, exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_tests++; if (got[gb + i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, got[gb + i], exp_q[i]); end
      end
    end
    n_tests++; if (byte_valid_o !== 1'b0 || overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_after valid=%b ovf=%b exp=0/1", byte_valid_o, overflow_o); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    int gb, eb;
    b = 8'h33;
    byte_ready_i = 1'b1;
    rx = 1'b0; tick(C);
    for (int i = 0; i < 4; i++) begin rx = b[i]; tick(C); end
    rx = b[4]; tick(4);
    n_tests++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before got=%b exp=1", busy_o); end
    rst_n = 1'b0; #2;
    n_tests++; if (busy_o !== 1'b0 || byte_valid_o !== 1'b0 || frame_err_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_flags busy=%b valid=%b ferr=%b exp=0/0/0", busy_o, byte_valid_o, frame_err_o); end
    n_tests++; if (overflow_o !== 1'b0 || drop_cnt_o !== 8'h00 || byte_o !== 8'h00) begin n_fail++; $display("FAIL mid_reset_vals ovf=%b drop=%0d byte=%h exp=0/0/00", overflow_o, drop_cnt_o, byte_o); end
    rx = 1'b1; tick(3);
    rst_n = 1'b1; tick(C);
    gb = got.size(); eb = err_hi;
    send_frame(8'hC3, 1'b1);
    tick(20);
    n_tests++; if (got.size() - gb != 1) begin n_fail++; $display("FAIL mid_count got=%0d exp=1", got.size() - gb); end
    else begin
      n_tests++; if (got[gb] !== 8'hC3) begin n_fail++; $display("FAIL mid_data got=%h exp=c3", got[gb]); end
    end
    n_tests++; if (err_hi != eb) begin n_fail++; $display("FAIL mid_ferr got=%0d exp=0", err_hi - eb); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_random();
    test_overflow();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
